// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings, responder FSM states and the byte-lane enable helper
// used by the on-chip SRAM responder.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slave_state_t;

    // Little-endian lane enables for a naturally aligned transfer.
    function automatic logic [3:0] be_from_size(input logic [2:0] size, input logic [1:0] addr);
        case (size)
            HSIZE_BYTE: be_from_size = 4'b0001 << addr;
            HSIZE_HALF: be_from_size = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be_from_size = 4'b1111;
            default:    be_from_size = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite responder-side signal bundle; the master modport is the bus/decoder side.
interface ahb_lite_sram_slave_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );

endinterface

// File: rtl/ahb_sram_array.sv
// 32-bit SRAM macro model: byte-lane write port and registered read port on one clock;
// a same-edge read of the word being written returns the old contents.
module ahb_sram_array #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              CLK,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    // NOTE: the storage has no reset; a reset branch would turn the array into flops
    // and contents must survive a mid-transfer reset anyway.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder: transfer acceptance, legality check, wait-state/error FSM
// and forwarding of a committing write into a back-to-back read of the same word.
module ahb_lite_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int unsigned MEM_WORDS_LOG2 = 12,
    parameter int unsigned WAIT_STATES    = 0,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
    input logic                  CLK,
    input logic                  nRST,
    ahb_lite_sram_slave_if.slave bus
);

    localparam int unsigned OFFS_W = MEM_WORDS_LOG2 + 2;

    slave_state_t              state;
    logic                      hreadyout_q;
    logic                      hresp_q;
    logic [2:0]                wait_cnt;
    logic [OFFS_W-1:0]         addr_q;
    logic                      write_q;
    logic [1:0]                size_q;
    logic [31:0]               hrdata_q;
    logic                      fwd_hit;
    logic [31:0]               fwd_data;
    logic [3:0]                fwd_be;

    logic [31:0]               offset;
    logic                      accept;
    logic                      acc_err;
    logic                      commit;
    logic [3:0]                commit_be;
    logic [3:0]                array_we;
    logic [MEM_WORDS_LOG2-1:0] rd_idx;
    logic [31:0]               arr_rdata;
    logic [31:0]               rd_word;
    logic                      unused_inputs;

    assign offset  = bus.HADDR - BASE_ADDR;
    assign accept  = bus.HSEL && bus.HREADY && bus.HTRANS[1];
    assign acc_err = (bus.HSIZE > HSIZE_WORD)
                  || (bus.HSIZE == HSIZE_HALF && bus.HADDR[0])
                  || (bus.HSIZE == HSIZE_WORD && bus.HADDR[1:0] != 2'b00)
                  || (offset[31:OFFS_W] != '0);

    assign commit    = (state == ST_DATA) && write_q;
    assign commit_be = be_from_size({1'b0, size_q}, addr_q[1:0]);
    assign array_we  = (commit && nRST) ? commit_be : 4'b0000;

    // While waiting, keep re-reading the latched word so the data phase sees committed data.
    assign rd_idx = (state == ST_WAIT) ? addr_q[OFFS_W-1:2] : offset[OFFS_W-1:2];

    ahb_sram_array #(
        .ADDR_W (MEM_WORDS_LOG2)
    ) u_array (
        .CLK   (CLK),
        .we    (array_we),
        .waddr (addr_q[OFFS_W-1:2]),
        .wdata (bus.HWDATA),
        .raddr (rd_idx),
        .rdata (arr_rdata)
    );

    // NOTE: rd_word gets its default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        rd_word = arr_rdata;
        for (int i = 0; i < 4; i++) begin
            if (fwd_hit && fwd_be[i]) rd_word[8*i +: 8] = fwd_data[8*i +: 8];
        end
    end

    // NOTE: all state here uses <= so every branch sees the pre-edge values of its peers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            wait_cnt    <= 3'd0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= 2'd0;
            hrdata_q    <= 32'h0;
            fwd_hit     <= 1'b0;
            fwd_data    <= 32'h0;
            fwd_be      <= 4'b0000;
        end else begin
            if (state == ST_DATA && !write_q) hrdata_q <= rd_word;

            unique case (state)
                ST_WAIT: begin
                    fwd_hit <= 1'b0;
                    if (wait_cnt == 3'd1) begin
                        state       <= ST_DATA;
                        hreadyout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                end
                default: begin
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                    if (!accept) begin
                        state <= ST_IDLE;
                    end else begin
                        addr_q   <= offset[OFFS_W-1:0];
                        write_q  <= bus.HWRITE;
                        size_q   <= bus.HSIZE[1:0];
                        fwd_hit  <= commit && !bus.HWRITE
                                 && (offset[OFFS_W-1:2] == addr_q[OFFS_W-1:2]);
                        fwd_data <= bus.HWDATA;
                        fwd_be   <= commit_be;
                        if (acc_err) begin
                            state       <= ST_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_ERROR;
                        end else if (WAIT_STATES != 0) begin
                            state       <= ST_WAIT;
                            wait_cnt    <= 3'(WAIT_STATES);
                            hreadyout_q <= 1'b0;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = (state == ST_DATA && !write_q) ? rd_word : hrdata_q;

    assign unused_inputs = ^{bus.HTRANS[0], bus.HBURST, bus.HPROT, bus.HMASTLOCK};

endmodule
